// File: rtl/state_sequencer_if.sv
// Board-side signal bundle for state_sequencer: raw button/switch inputs in,
// registered state and pulse outputs back to the output decoder.
// There is no valid/ready handshake on this bundle. The inputs are level
// signals sampled every clock. The outputs are registered and change only on
// the rising edge of clk.
interface state_sequencer_if;
  logic       btn_step;
  logic       dir;
  logic       auto_en;
  logic       load;
  logic [2:0] load_val;
  logic [2:0] current;
  logic       step_pulse;
  logic       wrap;

  modport master (
    output btn_step, dir, auto_en, load, load_val,
    input  current, step_pulse, wrap
  );

  modport slave (
    input  btn_step, dir, auto_en, load, load_val,
    output current, step_pulse, wrap
  );
endinterface

// File: rtl/state_sequencer.sv
// Produces the 3-bit displayed state. The state steps on a debounced button
// press, on an auto-advance timer, or on a direct load. Every output is
// registered, so no input reaches an output combinationally.
module state_sequencer #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int AUTO_PERIOD     = 8,
  parameter int MAX_STATE       = 7
) (
  input  logic               clk,
  input  logic               rst_n,
  state_sequencer_if.slave   bus
);

  localparam int DW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int AW = (AUTO_PERIOD > 2) ? $clog2(AUTO_PERIOD) : 1;
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [AW-1:0] AUTO_LAST = AW'(AUTO_PERIOD - 1);
  // A 4-bit copy of the limit keeps the range checks meaningful when the
  // limit is 7.
  localparam logic [3:0]    MAX_W     = 4'(MAX_STATE);
  localparam logic [2:0]    MAX_S     = 3'(MAX_STATE);

  logic          sync1, sync2;
  logic          deb, deb_d;
  logic [DW-1:0] deb_cnt;
  logic [AW-1:0] auto_cnt;
  logic [2:0]    cur_q, cur_next;
  logic          step_q, step_next;
  logic          wrap_q, wrap_next;
  logic          man_req, auto_req, step_req;

  // Two-flop synchronizer for the asynchronous push-button.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= bus.btn_step;
      sync2 <= sync1;
    end
  end

  // The debounced level flips only after DEBOUNCE_CYCLES consecutive
  // disagreeing samples. deb_d delays it so that a press can be detected.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb     <= 1'b0;
      deb_d   <= 1'b0;
      deb_cnt <= '0;
    end else begin
      deb_d <= deb;
      if (sync2 == deb) begin
        deb_cnt <= '0;
      end else if (deb_cnt < DEB_LAST) begin
        deb_cnt <= deb_cnt + 1'b1;
      end else begin
        deb     <= sync2;
        deb_cnt <= '0;
      end
    end
  end

  // The auto-advance timer counts 0..AUTO_PERIOD-1 while enabled and is held
  // at 0 while auto_en is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      auto_cnt <= '0;
    end else if (!bus.auto_en || auto_cnt == AUTO_LAST) begin
      auto_cnt <= '0;
    end else begin
      auto_cnt <= auto_cnt + 1'b1;
    end
  end

  assign man_req  = deb & ~deb_d;
  assign auto_req = bus.auto_en & (auto_cnt == AUTO_LAST);
  assign step_req = man_req | auto_req;

  // Next state: load wins over a step, and a step can wrap in either direction.
  always_comb begin
    cur_next  = cur_q;
    step_next = 1'b0;
    wrap_next = 1'b0;
    if (bus.load) begin
      cur_next = ({1'b0, bus.load_val} > MAX_W) ? MAX_S : bus.load_val;
    end else if (step_req) begin
      step_next = 1'b1;
      if ({1'b0, cur_q} > MAX_W) begin
        cur_next  = 3'd0;
        wrap_next = 1'b1;
      end else if (bus.dir) begin
        if (cur_q == MAX_S) begin
          cur_next  = 3'd0;
          wrap_next = 1'b1;
        end else begin
          cur_next = cur_q + 3'd1;
        end
      end else begin
        if (cur_q == 3'd0) begin
          cur_next  = MAX_S;
          wrap_next = 1'b1;
        end else begin
          cur_next = cur_q - 3'd1;
        end
      end
    end
  end

  // Registered state and the one-cycle step/wrap pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_q  <= 3'd0;
      step_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      cur_q  <= cur_next;
      step_q <= step_next;
      wrap_q <= wrap_next;
    end
  end

  assign bus.current    = cur_q;
  assign bus.step_pulse = step_q;
  assign bus.wrap       = wrap_q;

endmodule
